shift_sched: RTL and testbench



---
 rtl/shift_sched.sv | 105 ++++++++++
 tb/tb_shift_sched.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// Round-robin two-port front end for a bit-serial shifter: one command in flight, one bit per clock.
// Latency amt+1 cycles from accept; DONE holds the response until rsp_ready, and ready stays low outside IDLE.
module shift_sched #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [2:0]       req0_op,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [2:0]       req1_op,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op;
  logic             id, err, last;

  logic             grant0, grant1, accept;
  logic [WIDTH-1:0] sel_data;
  logic [2:0]       sel_op;
  logic [AMT_W-1:0] sel_amt;

  // On a tie, the port that did not win last time gets the grant.
  assign grant0 = req0_valid & (~req1_valid | last);
  assign grant1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_data = req1_ready ? req1_data : req0_data;
  assign sel_op   = req1_ready ? req1_op   : req0_op;
  assign sel_amt  = req1_ready ? req1_amt  : req0_amt;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic [2:0] o);
    case (o)
      3'd0, 3'd2: step = {a[WIDTH-2:0], 1'b0};
      3'd1:       step = {1'b0, a[WIDTH-1:1]};
      3'd3:       step = {a[WIDTH-1], a[WIDTH-1:1]};
      3'd4:       step = {a[WIDTH-2:0], a[WIDTH-1]};
      3'd5:       step = {a[0], a[WIDTH-1:1]};
      default:    step = a;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (sel_amt != '0) ? SHIFT : DONE;
      SHIFT: if (cnt == AMT_W'(1)) state_nxt = DONE;
      DONE:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op    <= '0;
      id    <= 1'b0;
      err   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc  <= sel_data;
        cnt  <= sel_amt;
        op   <= sel_op;
        id   <= req1_ready;
        err  <= (sel_op > 3'd5);
        last <= req1_ready;
      end else if (state == SHIFT) begin
        // Repeated single-bit steps give saturation and modulo wrap for large amounts for free.
        acc <= step(acc, op);
        cnt <= cnt - AMT_W'(1);
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_valid ? acc : '0;
  assign rsp_id    = rsp_valid & id;
  assign rsp_err   = rsp_valid & err;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: shift ops, saturation/wrap, round-robin, stall and async reset.
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_data, req1_data;
  logic [2:0] req0_op, req1_op, req0_amt, req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [3:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_sched #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_op(req0_op), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_op(req1_op), .req1_amt(req1_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input logic [3:0] d, input logic [2:0] o, input logic [2:0] a);
    if (port) begin
      req1_valid = 1'b1; req1_data = d; req1_op = o; req1_amt = a;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_op = o; req0_amt = a;
    end
  endtask

  // Issue one command on an idle block with rsp_ready high and check the whole response.
  task automatic do_cmd(input string tag, input bit port, input logic [3:0] d, input logic [2:0] o,
                        input logic [2:0] a, input logic [3:0] exp_d, input bit exp_err);
    int lat;
    @(negedge clk);
    drive(port, d, o, a);
    #1;
    chk({tag, "_ready"}, 32'(port ? req1_ready : req0_ready), 32'(1));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(int'(a) + 1));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, "_id"}, 32'(rsp_id), 32'(port));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_idle"}, 32'({busy, rsp_valid}), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 4'h0; req0_op = 3'd0; req0_amt = 3'd0;
    req1_data = 4'h0; req1_op = 3'd0; req1_amt = 3'd0;
    #1;
    chk("reset_outs", 32'({rsp_valid, rsp_data, rsp_id, rsp_err, busy, req0_ready, req1_ready}), 32'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Round-robin with both ports valid: LSR by 1 of 0001 (port0) and 1000 (port1).
    @(negedge clk);
    drive(1'b0, 4'b0001, 3'd1, 3'd1);
    drive(1'b1, 4'b1000, 3'd1, 3'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("rr_grant", 32'({req1_ready, req0_ready}), (k % 2) ? 32'h2 : 32'h1);
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk); n++;
      end
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
      chk("rr_data", 32'(rsp_data), (k % 2) ? 32'h4 : 32'h0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    do_cmd("lsr1",    1'b0, 4'b1011, 3'd1, 3'd1, 4'b0101, 1'b0);
    do_cmd("asr2",    1'b1, 4'b1011, 3'd3, 3'd2, 4'b1110, 1'b0);
    do_cmd("asr7",    1'b0, 4'b1011, 3'd3, 3'd7, 4'b1111, 1'b0);
    do_cmd("lsl5",    1'b1, 4'b1011, 3'd0, 3'd5, 4'b0000, 1'b0);
    do_cmd("amt0",    1'b0, 4'b1011, 3'd0, 3'd0, 4'b1011, 1'b0);
    do_cmd("rol5",    1'b1, 4'b1001, 3'd4, 3'd5, 4'b0011, 1'b0);
    do_cmd("ror1",    1'b0, 4'b1001, 3'd5, 3'd1, 4'b1100, 1'b0);
    do_cmd("asl1",    1'b1, 4'b0110, 3'd2, 3'd1, 4'b1100, 1'b0);
    do_cmd("illegal", 1'b0, 4'b0101, 3'd6, 3'd2, 4'b0101, 1'b1);

    // Response stall: ROR 1100 by 1 on port1 -> 0110, held while rsp_ready is low.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b1, 4'b1100, 3'd5, 3'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    drive(1'b0, 4'b1111, 3'd0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_rsp", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 32'({1'b1, 4'b0110, 1'b1, 1'b0}));
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'(0));
      @(negedge clk);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'({busy, rsp_valid}), 32'(0));

    // Async reset mid-shift of an amt-6 command from port0 (last now 0, so req1 would win a tie).
    @(negedge clk);
    drive(1'b0, 4'b1111, 3'd0, 3'd6);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    drive(1'b0, 4'b0011, 3'd0, 3'd0);
    drive(1'b1, 4'b0011, 3'd0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({rsp_valid, rsp_data, rsp_id, rsp_err, busy, req0_ready, req1_ready}), 32'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'({rsp_valid, busy}), 32'(0));
    end
    rst_n = 1'b1;
    #1;
    chk("rst_rr_grant", 32'({req1_ready, req0_ready}), 32'h1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    do_cmd("lone_req1", 1'b1, 4'b0110, 3'd4, 3'd1, 4'b1100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
